// File: rtl/pu_seq_controller_if.sv
// rtl/pu_seq_controller_if.sv - control bundle between layer controller, PU sequencer and PU datapath
//
// Parameter:
//   CNT_W      width of the MAC round index
// Signals:
//   start      request a neuron computation (layer controller -> sequencer)
//   abort      synchronous abort back to IDLE (layer controller -> sequencer)
//   out_ack    result accepted by the consumer (layer controller -> sequencer)
//   round      current MAC index / weight-data address (sequencer -> datapath)
//   data_ld    load input-data register
//   acc_clr    clear accumulator
//   acc_en     accumulator update enable
//   bias_en    steer bias into the adder
//   act_en     activation-stage enable
//   out_ld     load output register
//   out_valid  result available
//   busy       sequencer not idle
// Modports:
//   master     layer-controller / datapath view
//   slave      sequencer view
interface pu_seq_controller_if #(
  parameter int CNT_W = 4
) ();
  logic             start;
  logic             abort;
  logic             out_ack;
  logic [CNT_W-1:0] round;
  logic             data_ld;
  logic             acc_clr;
  logic             acc_en;
  logic             bias_en;
  logic             act_en;
  logic             out_ld;
  logic             out_valid;
  logic             busy;

  modport master (
    output start, abort, out_ack,
    input  round, data_ld, acc_clr, acc_en, bias_en, act_en, out_ld, out_valid, busy
  );

  modport slave (
    input  start, abort, out_ack,
    output round, data_ld, acc_clr, acc_en, bias_en, act_en, out_ld, out_valid, busy
  );
endinterface

// File: rtl/pu_seq_controller.sv
// rtl/pu_seq_controller.sv - sequencing controller for one MLP neuron processing unit
//
// Sequence per neuron: IDLE -> MAC (N_INPUTS rounds) -> [DRAIN] -> BIAS -> ACT -> DONE,
// with a valid/ack result handshake and a synchronous abort that wins over everything.
//
// Optional feature macro: PU_MULT_PIPE_EN
//   defined   registered multiplier: DRAIN state after MAC, acc_en low in the first
//             MAC cycle, latency start -> out_valid of N_INPUTS+4 cycles
//   undefined no DRAIN, latency N_INPUTS+3 cycles
//
// Parameters:
//   N_INPUTS   MAC rounds per neuron (>= 1)
//   CNT_W      round index width (2**CNT_W >= N_INPUTS)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        pu_seq_controller_if.slave: start/abort/out_ack in, control strobes out
module pu_seq_controller #(
  parameter int N_INPUTS = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pu_seq_controller_if.slave   bus
);

`ifdef PU_MULT_PIPE_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_BIAS  = 3'd2,
    S_ACT   = 3'd3,
    S_DONE  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_BIAS  = 3'd2,
    S_ACT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(N_INPUTS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] round_q, round_nxt;
  logic             acc_clr_q, acc_en_q, bias_en_q, act_en_q, out_ld_q, out_valid_q, busy_q;
  logic             acc_en_nxt;

  // Next-state and next-round selection; abort overrides every other condition.
  always_comb begin
    state_nxt = state;
    round_nxt = round_q;
    if (bus.abort) begin
      state_nxt = S_IDLE;
      round_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          round_nxt = '0;
          if (bus.start) state_nxt = S_MAC;
        end
        S_MAC: begin
          if (round_q == LAST_ROUND) begin
`ifdef PU_MULT_PIPE_EN
            state_nxt = S_DRAIN;
`else
            state_nxt = S_BIAS;
`endif
          end else begin
            round_nxt = round_q + 1'b1;
          end
        end
`ifdef PU_MULT_PIPE_EN
        S_DRAIN: state_nxt = S_BIAS;
`endif
        S_BIAS: state_nxt = S_ACT;
        S_ACT:  state_nxt = S_DONE;
        S_DONE: begin
          if (bus.out_ack) begin
            state_nxt = S_IDLE;
            round_nxt = '0;
          end
        end
        default: begin
          // unused encodings fall back to IDLE
          state_nxt = S_IDLE;
          round_nxt = '0;
        end
      endcase
    end
  end

  // The multiplier register delays products by one cycle, so the first MAC cycle
  // has nothing to accumulate yet and DRAIN picks up the last product.
`ifdef PU_MULT_PIPE_EN
  assign acc_en_nxt = ((state_nxt == S_MAC) && (round_nxt != '0)) ||
                      (state_nxt == S_DRAIN) || (state_nxt == S_BIAS);
`else
  assign acc_en_nxt = (state_nxt == S_MAC) || (state_nxt == S_BIAS);
`endif

  // Moore outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      round_q     <= '0;
      acc_clr_q   <= 1'b1;
      acc_en_q    <= 1'b0;
      bias_en_q   <= 1'b0;
      act_en_q    <= 1'b0;
      out_ld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      round_q     <= round_nxt;
      acc_clr_q   <= (state_nxt == S_IDLE);
      acc_en_q    <= acc_en_nxt;
      bias_en_q   <= (state_nxt == S_BIAS);
      act_en_q    <= (state_nxt == S_ACT);
      out_ld_q    <= (state_nxt == S_ACT);
      out_valid_q <= (state_nxt == S_DONE);
      busy_q      <= (state_nxt != S_IDLE);
    end
  end

  // data_ld is the only Mealy output: it loads the first data word in the start cycle.
  assign bus.data_ld   = rst_n && (state == S_IDLE) && bus.start && !bus.abort;
  assign bus.round     = round_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.bias_en   = bias_en_q;
  assign bus.act_en    = act_en_q;
  assign bus.out_ld    = out_ld_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pu_seq_controller.sv
// tb/tb_pu_seq_controller.sv - self-checking bench for pu_seq_controller
module tb_pu_seq_controller;
  localparam int N     = 8;
  localparam int CNT_W = 4;
  localparam int VW    = CNT_W + 7;
`ifdef PU_MULT_PIPE_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DONE_T = N + 3 + P;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  pu_seq_controller_if #(.CNT_W(CNT_W)) ifc ();

  pu_seq_controller #(.N_INPUTS(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs();
    return {ifc.busy, ifc.out_valid, ifc.out_ld, ifc.act_en, ifc.bias_en,
            ifc.acc_en, ifc.acc_clr, ifc.round};
  endfunction

  function automatic logic [VW-1:0] mk(bit busy, bit ov, bit ol, bit ae, bit be,
                                       bit acc, bit clr, int r);
    logic [CNT_W-1:0] rr;
    rr = CNT_W'(r);
    return {busy, ov, ol, ae, be, acc, clr, rr};
  endfunction

  // Expected outputs t cycles after start was accepted (t=0 means idle).
  function automatic logic [VW-1:0] expect_at(int t);
    if (t == 0)             return mk(0, 0, 0, 0, 0, 0, 1, 0);
    if (t <= N)             return mk(1, 0, 0, 0, 0, (P == 0) || (t > 1), 0, t - 1);
    if (P == 1 && t == N+1) return mk(1, 0, 0, 0, 0, 1, 0, N - 1);
    if (t == N + 1 + P)     return mk(1, 0, 0, 0, 1, 1, 0, N - 1);
    if (t == N + 2 + P)     return mk(1, 0, 1, 1, 0, 0, 0, N - 1);
    return mk(1, 1, 0, 0, 0, 0, 0, N - 1);
  endfunction

  task automatic chkv(input string tag, input logic [VW-1:0] o, input logic [VW-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chki(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One neuron run starting from idle, sampled 1ns after a rising edge.
  task automatic run(input int ack_delay, input int abort_at, input int spur_at,
                     input bit ack_with_start, input string name);
    int t;
    int done_cnt;
    int acc_cnt;
    int first_valid;
    bit fin;
    bit aborted;
    ifc.start = 1'b1;
    ifc.abort = (abort_at == 0);
    #1;
    chki({name, ":data_ld"}, int'(ifc.data_ld), (abort_at != 0) ? 1 : 0);
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    if (abort_at == 0) begin
      chkv({name, ":abort_idle"}, obs(), expect_at(0));
      return;
    end
    t = 1; done_cnt = 0; acc_cnt = 0; first_valid = -1; fin = 0; aborted = 0;
    while (!fin && t < 300) begin
      chkv($sformatf("%s:t%0d", name, t), obs(), expect_at(t));
      if (ifc.acc_en && !ifc.bias_en) acc_cnt++;
      if (ifc.out_valid && first_valid < 0) first_valid = t;
      if (t == abort_at) begin
        ifc.abort = 1'b1;
        aborted = 1;
        fin = 1;
      end else if (t >= DONE_T && done_cnt == ack_delay) begin
        ifc.out_ack = 1'b1;
        ifc.start = ack_with_start;
        fin = 1;
      end else if (t == spur_at) begin
        ifc.start = 1'b1;
        #1;
        chki({name, ":spur_data_ld"}, int'(ifc.data_ld), 0);
      end
      if (t >= DONE_T) done_cnt++;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      ifc.out_ack = 1'b0;
      t++;
    end
    if (!fin) chki({name, ":timeout"}, 0, 1);
    chkv({name, ":idle_after"}, obs(), expect_at(0));
    if (!aborted) chki({name, ":acc_cycles"}, acc_cnt, N);
    if (abort_at < 0 || abort_at >= DONE_T)
      chki({name, ":latency"}, first_valid, DONE_T);
    else
      chki({name, ":no_valid"}, first_valid, -1);
    @(posedge clk); #1;
    chkv({name, ":not_queued"}, obs(), expect_at(0));
  endtask

  initial begin
    rst_n = 1'b1;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    ifc.out_ack = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chkv("reset_async", obs(), expect_at(0));
    chki("reset_data_ld", int'(ifc.data_ld), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chkv("idle_after_reset", obs(), expect_at(0));

    // Idle noise: ack/abort without start must not leave IDLE.
    for (int i = 0; i < 4; i++) begin
      ifc.out_ack = 1'($urandom_range(0, 1));
      ifc.abort = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      ifc.out_ack = 1'b0;
      ifc.abort = 1'b0;
      chkv($sformatf("idle_noise%0d", i), obs(), expect_at(0));
    end

    run(0, -1, -1, 0, "single");
    run(5, -1, -1, 0, "hold5");
    run(0, -1, 4, 0, "spur_r3");
    run(0, 6, -1, 0, "abort_r5");
    run(1, -1, -1, 0, "after_abort");
    run(0, -1, -1, 1, "ack_start");
    run(3, DONE_T + 1, -1, 0, "abort_done");
    run(0, 0, -1, 0, "abort_start");

    for (int i = 0; i < 12; i++) begin
      int ad;
      int ab;
      int sp;
      ad = $urandom_range(0, 6);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DONE_T + 3)) : -1;
      sp = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, DONE_T + 2)) : -1;
      run(ad, ab, sp, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in BIAS, mid-cycle.
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (N + P) @(posedge clk);
    #1;
    chkv("pre_reset_bias", obs(), expect_at(N + 1 + P));
    #2 rst_n = 1'b0;
    #1;
    chkv("reset_mid_bias", obs(), expect_at(0));
    @(posedge clk); #1;
    chkv("reset_held", obs(), expect_at(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chkv("reset_release", obs(), expect_at(0));
    run(0, -1, -1, 0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pu_seq_controller.md
Name: pu_seq_controller

Overview:
- Parametrised sequencing controller for one MLP neuron processing unit (PU): multiply-accumulate over N_INPUTS weight/data pairs, add bias, apply activation, present the result.
- Successor to the fixed 8-round PU controller. Adds:
  - configurable input count and counter width;
  - explicit bias and activation phases;
  - a valid/ack output handshake;
  - a synchronous abort.
- Sits between the layer controller (start/abort, out_ack) and the PU datapath (MAC, bias adder, activation, output register).

Parameters:
- N_INPUTS, 8, number of MAC rounds per neuron; must be >= 1.
- CNT_W, 4, width of the round index; 2^CNT_W >= N_INPUTS required.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a neuron computation; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- out_ack  in  1  consumer accepted the result.
- round  out  CNT_W  current MAC index, used as weight/data address.
- data_ld  out  1  load the input-data register.
- acc_clr  out  1  clear the accumulator.
- acc_en  out  1  accumulator update enable.
- bias_en  out  1  steer bias into the adder.
- act_en  out  1  activation-stage enable.
- out_ld  out  1  load the output register.
- out_valid  out  1  result available.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst_n is asynchronous and active-low; one clock, clk. While rst_n=0: state=IDLE, round=0, all outputs 0 except acc_clr=1, the IDLE Moore value.
- All control outputs are Moore, decoded from state only. round is a registered counter.
- IDLE:
  - acc_clr=1; round held at 0.
  - start=1 -> data_ld=1 in this cycle (Mealy on start, IDLE only), next state MAC.
- MAC:
  - acc_en=1; round increments by 1 each cycle.
  - When round==N_INPUTS-1 -> next state BIAS, round holds.
  - Exactly N_INPUTS acc_en cycles; round takes values 0..N_INPUTS-1 once each.
- BIAS: bias_en=1, acc_en=1 for one cycle -> ACT.
- ACT: act_en=1, out_ld=1 for one cycle -> DONE.
- DONE:
  - out_valid=1; holds until out_ack=1.
  - On out_ack -> IDLE; round cleared to 0 on that edge.
- Latency: start sampled at edge k -> out_valid first high after edge k+N_INPUTS+2, i.e. N_INPUTS+3 cycles after start was accepted.
- start outside IDLE is ignored and not queued. start and out_ack both high in DONE -> IDLE only; a new start is needed in IDLE.
- abort=1 in any state -> IDLE next edge, round=0, out_valid drops.
  - abort has priority over start, out_ack and count completion.
  - abort with start in IDLE -> stay IDLE, data_ld=0.
- N_INPUTS=1: MAC lasts exactly one cycle with round=0.
- round never exceeds N_INPUTS-1; no wrap-around.
- An unused state encoding recovers to IDLE on the next edge.
- Reset asserted mid-operation: immediate return to reset values; no residual out_valid.

Optional Feature:
- Macro: PU_MULT_PIPE_EN.
- Defined (registered multiplier, one cycle of latency):
  - State DRAIN is inserted between MAC and BIAS.
  - acc_en=0 in the first MAC cycle; acc_en=1 in the remaining MAC cycles and in DRAIN; round holds in DRAIN.
  - acc_en count is still N_INPUTS. Latency becomes N_INPUTS+4.
  - abort behaviour is unchanged.
- Undefined: no DRAIN state; timing exactly as in Behaviour.

Test Plan:
- Reset then single run, N_INPUTS=8:
  - Drive start one cycle -> data_ld pulses once.
  - round steps 0..7 with acc_en high for 8 cycles, then bias_en for 1 cycle, then act_en/out_ld for 1 cycle.
  - out_valid rises 11 cycles after start; busy high throughout.
- Handshake hold: withhold out_ack for 5 cycles -> out_valid stays 1 and round stays 7. Assert out_ack -> IDLE next edge, round=0, acc_clr=1.
- Ignored start: pulse start during MAC at round=3 -> sequence unchanged; exactly 8 acc_en cycles.
- Abort: assert abort at round=5 -> next edge IDLE, busy=0, out_valid never asserted. A following start produces a clean full run.
- Async reset: drop rst_n in BIAS mid-cycle -> outputs go to reset values immediately without a clock edge. With N_INPUTS=1 (rebuild): acc_en high exactly 1 cycle and out_valid 4 cycles after start.
- PU_MULT_PIPE_EN defined, N_INPUTS=8:
  - acc_en low in the first MAC cycle, then high for 7 MAC cycles + 1 DRAIN cycle.
  - out_valid 12 cycles after start.
